// File: rtl/mpcache_pkg.sv
// ---------------------------------------------------------------------------
// mpcache_pkg
// Shared constants and types for the packet-cache read path.
//   DATA_WIDTH      SRAM word / stream data width
//   BLK_ADDR_WIDTH  block address width
//   BLK_WORDS_LOG2  log2 of words per block
//   LEN_WIDTH       packet length field width (words, CRC word excluded)
//   oc_state_e      output_channel FSM states
//   sram_addr_t     {block, word offset} SRAM word address
//   crc32_step      one 32-bit data step of CRC-32 (poly 04C11DB7, MSB first)
// ---------------------------------------------------------------------------
package mpcache_pkg;
   localparam int DATA_WIDTH     = 32;
   localparam int BLK_ADDR_WIDTH = 8;
   localparam int BLK_WORDS_LOG2 = 3;
   localparam int LEN_WIDTH      = 12;
   localparam int SRAM_AW        = BLK_ADDR_WIDTH + BLK_WORDS_LOG2;

   localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

   typedef logic [SRAM_AW-1:0] sram_addr_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      LINK = 3'd2,
      CRC  = 3'd3,
      DONE = 3'd4
   } oc_state_e;

   // Data bits are folded in MSB first; no reflection, no final XOR.
   function automatic logic [31:0] crc32_step(input logic [31:0] c_in,
                                              input logic [31:0] d);
      logic [31:0] c;
      logic        fb;
      c = c_in;
      for (int i = 31; i >= 0; i--) begin
         fb = c[31] ^ d[i];
         c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
      end
      return c;
   endfunction
endpackage

// File: rtl/crc32_d32.sv
// ---------------------------------------------------------------------------
// crc32_d32
// Running CRC-32 over 32-bit words.
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_clr         restart at CRC32_INIT
//   i_en          fold i_data into the running value
//   o_crc         current CRC value
// ---------------------------------------------------------------------------
module crc32_d32
   import mpcache_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic [31:0] i_data,
   output logic [31:0] o_crc
);
   logic [31:0] r_crc;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) r_crc <= CRC32_INIT;
      else if (i_en)      r_crc <= crc32_step(r_crc, i_data);
   end

   assign o_crc = r_crc;
endmodule

// File: rtl/output_channel_skid.sv
// ---------------------------------------------------------------------------
// oc_skid_buf
// 2-entry valid/ready buffer. Pushes are never refused: the producer is
// credit-limited so a push never arrives while full without a pop.
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_push/i_data write side
//   i_rdy         consumer ready (pop = o_vld && i_rdy)
//   o_vld/o_data  head entry, held stable until popped
//   o_cnt         occupancy 0..2
// ---------------------------------------------------------------------------
module oc_skid_buf #(
   parameter int W = 34
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_rdy,
   output logic         o_vld,
   output logic [W-1:0] o_data,
   output logic [1:0]   o_cnt
);
   logic [W-1:0] r_q0, r_q1;
   logic [1:0]   r_cnt;
   logic         w_pop;

   assign w_pop = (r_cnt != 2'd0) && i_rdy;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q0  <= '0;
         r_q1  <= '0;
         r_cnt <= 2'd0;
      end else begin
         case ({i_push, w_pop})
            2'b10: begin
               if (r_cnt == 2'd0) r_q0 <= i_data;
               else               r_q1 <= i_data;
               r_cnt <= r_cnt + 2'd1;
            end
            2'b01: begin
               r_q0  <= r_q1;
               r_cnt <= r_cnt - 2'd1;
            end
            2'b11: begin
               if (r_cnt == 2'd1) r_q0 <= i_data;
               else begin
                  r_q0 <= r_q1;
                  r_q1 <= i_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_vld  = (r_cnt != 2'd0);
   assign o_data = r_q0;
   assign o_cnt  = r_cnt;
endmodule

// File: rtl/output_channel.sv
// ---------------------------------------------------------------------------
// output_channel
// Fetches a packet from shared SRAM by following the block link chain,
// streams the payload with backpressure, reads and checks the trailing CRC
// word and returns every drained block.
//   descriptor : i_desc_vld/i_desc_blk_addr/i_desc_len -> o_desc_rdy
//   link lookup: o_link_req/o_link_cur -> i_link_vld/i_link_addr
//   SRAM read  : o_sram_rd_en/o_sram_rd_addr -> i_sram_rd_data (1 cycle)
//   stream     : o_sop/o_rd_vld/o_rd_data/o_eop <- i_rd_rdy
//   status     : o_crc_err, o_blk_free_vld/o_blk_free_addr
// Build option: OUTPUT_CHANNEL_CRC_CHECK_EN enables CRC recomputation;
// without it o_crc_err is tied 0 but the CRC word is still read.
// ---------------------------------------------------------------------------
module output_channel
   import mpcache_pkg::*;
(
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_desc_vld,
   input  logic [BLK_ADDR_WIDTH-1:0]         i_desc_blk_addr,
   input  logic [LEN_WIDTH-1:0]              i_desc_len,
   output logic                              o_desc_rdy,
   output logic                              o_link_req,
   output logic [BLK_ADDR_WIDTH-1:0]         o_link_cur,
   input  logic                              i_link_vld,
   input  logic [BLK_ADDR_WIDTH-1:0]         i_link_addr,
   output logic                              o_sram_rd_en,
   output logic [BLK_ADDR_WIDTH+BLK_WORDS_LOG2-1:0] o_sram_rd_addr,
   input  logic [DATA_WIDTH-1:0]             i_sram_rd_data,
   output logic                              o_sop,
   output logic                              o_rd_vld,
   output logic [DATA_WIDTH-1:0]             o_rd_data,
   output logic                              o_eop,
   input  logic                              i_rd_rdy,
   output logic                              o_crc_err,
   output logic                              o_blk_free_vld,
   output logic [BLK_ADDR_WIDTH-1:0]         o_blk_free_addr
);
   oc_state_e                   r_state;
   logic [BLK_ADDR_WIDTH-1:0]   r_blk;
   logic [BLK_WORDS_LOG2-1:0]   r_off;
   logic [LEN_WIDTH-1:0]        r_rem, r_len;
   logic                        r_rdy, r_link_req, r_free_vld, r_crc_err;
   logic [BLK_ADDR_WIDTH-1:0]   r_free_addr;
   // tags of the read whose data returns this cycle
   logic                        r_dvld, r_dcrc, r_dsop, r_deop;
   logic                        r_crc_got;

   logic                        w_accept, w_pop, w_credit, w_issue, w_push;
   logic                        w_drained, w_crc_bad;
   logic [2:0]                  w_fill;
   logic                        w_sk_vld;
   logic [1:0]                  w_sk_cnt;
   logic [DATA_WIDTH+1:0]       w_sk_data;

   assign w_accept = i_desc_vld && r_rdy;
   assign w_push   = r_dvld && !r_dcrc;
   assign w_pop    = w_sk_vld && i_rd_rdy;

   // Credit: buffered words plus the word returning this cycle, less the
   // word leaving this cycle, must leave room for one more. Counting the
   // pop keeps 1 word/cycle through a 2-entry buffer with SRAM latency 1.
   assign w_fill   = {1'b0, w_sk_cnt} + {2'b00, r_dvld};
   assign w_credit = (w_fill < 3'd2) || (w_pop && (w_fill == 3'd2));
   assign w_issue  = ((r_state == READ) || (r_state == CRC)) && w_credit;

   assign w_drained = !w_sk_vld && !r_dvld && r_crc_got;

`ifdef OUTPUT_CHANNEL_CRC_CHECK_EN
   logic [DATA_WIDTH-1:0] r_crc_word;
   logic [31:0]           w_crc_calc;

   crc32_d32 u_crc (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (w_accept),
      .i_en   (w_push),
      .i_data (i_sram_rd_data),
      .o_crc  (w_crc_calc)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst)                r_crc_word <= '0;
      else if (r_dvld && r_dcrc) r_crc_word <= i_sram_rd_data;
   end

   assign w_crc_bad = (w_crc_calc != r_crc_word);
`else
   assign w_crc_bad = 1'b0;
`endif

   oc_skid_buf #(.W(DATA_WIDTH + 2)) u_skid (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_push (w_push),
      .i_data ({r_dsop, r_deop, i_sram_rd_data}),
      .i_rdy  (i_rd_rdy),
      .o_vld  (w_sk_vld),
      .o_data (w_sk_data),
      .o_cnt  (w_sk_cnt)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_blk       <= '0;
         r_off       <= '0;
         r_rem       <= '0;
         r_len       <= '0;
         r_rdy       <= 1'b0;
         r_link_req  <= 1'b0;
         r_free_vld  <= 1'b0;
         r_free_addr <= '0;
         r_crc_err   <= 1'b0;
         r_dvld      <= 1'b0;
         r_dcrc      <= 1'b0;
         r_dsop      <= 1'b0;
         r_deop      <= 1'b0;
         r_crc_got   <= 1'b0;
      end else begin
         r_link_req <= 1'b0;
         r_free_vld <= 1'b0;
         r_crc_err  <= 1'b0;

         r_dvld <= w_issue;
         r_dcrc <= (r_state == CRC);
         r_dsop <= (r_state == READ) && (r_rem == r_len);
         r_deop <= (r_state == READ) && (r_rem == LEN_WIDTH'(1));
         if (r_dvld && r_dcrc) r_crc_got <= 1'b1;

         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_rdy     <= 1'b0;
                  r_blk     <= i_desc_blk_addr;
                  r_off     <= '0;
                  r_rem     <= i_desc_len;
                  r_len     <= i_desc_len;
                  r_crc_got <= 1'b0;
                  r_state   <= (i_desc_len == '0) ? CRC : READ;
               end else begin
                  r_rdy <= 1'b1;
               end
            end
            READ: begin
               if (w_issue) begin
                  r_off <= r_off + 1'b1;
                  if (r_rem != '0) r_rem <= r_rem - 1'b1;
                  // Any read at the last offset still leaves at least the
                  // CRC word outstanding, so a wrap always needs the link.
                  if (&r_off) begin
                     r_state     <= LINK;
                     r_link_req  <= 1'b1;
                     r_free_vld  <= 1'b1;
                     r_free_addr <= r_blk;
                  end else if (r_rem == LEN_WIDTH'(1)) begin
                     r_state <= CRC;
                  end
               end
            end
            LINK: begin
               // The lookup cannot answer in the request cycle.
               if (i_link_vld && !r_link_req) begin
                  r_blk   <= i_link_addr;
                  r_off   <= '0;
                  r_state <= (r_rem == '0) ? CRC : READ;
               end
            end
            CRC: begin
               if (w_issue) begin
                  r_off   <= r_off + 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (w_drained) begin
                  r_free_vld  <= 1'b1;
                  r_free_addr <= r_blk;
                  r_crc_err   <= w_crc_bad;
                  r_rdy       <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_desc_rdy      = r_rdy;
   assign o_link_req      = r_link_req;
   assign o_link_cur      = r_link_req ? r_free_addr : '0;
   assign o_blk_free_vld  = r_free_vld;
   assign o_blk_free_addr = r_free_vld ? r_free_addr : '0;
   assign o_crc_err       = r_crc_err;
   assign o_sram_rd_en    = w_issue;
   assign o_sram_rd_addr  = w_issue ? {r_blk, r_off} : '0;
   assign o_rd_vld        = w_sk_vld;
   assign o_sop           = w_sk_vld & w_sk_data[DATA_WIDTH+1];
   assign o_eop           = w_sk_vld & w_sk_data[DATA_WIDTH];
   assign o_rd_data       = w_sk_vld ? w_sk_data[DATA_WIDTH-1:0] : '0;
endmodule

// File: tb/tb_output_channel.sv
module tb_output_channel;
   import mpcache_pkg::*;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_desc_vld;
   logic [7:0]  i_desc_blk_addr;
   logic [11:0] i_desc_len;
   logic        o_desc_rdy, o_link_req, i_link_vld;
   logic [7:0]  o_link_cur, i_link_addr;
   logic        o_sram_rd_en;
   logic [10:0] o_sram_rd_addr;
   logic [31:0] i_sram_rd_data;
   logic        o_sop, o_rd_vld, o_eop, i_rd_rdy, o_crc_err, o_blk_free_vld;
   logic [31:0] o_rd_data;
   logic [7:0]  o_blk_free_addr;

   always #5 clk = ~clk;

   output_channel dut (
      .i_clk(clk), .i_rst(i_rst),
      .i_desc_vld(i_desc_vld), .i_desc_blk_addr(i_desc_blk_addr),
      .i_desc_len(i_desc_len), .o_desc_rdy(o_desc_rdy),
      .o_link_req(o_link_req), .o_link_cur(o_link_cur),
      .i_link_vld(i_link_vld), .i_link_addr(i_link_addr),
      .o_sram_rd_en(o_sram_rd_en), .o_sram_rd_addr(o_sram_rd_addr),
      .i_sram_rd_data(i_sram_rd_data),
      .o_sop(o_sop), .o_rd_vld(o_rd_vld), .o_rd_data(o_rd_data), .o_eop(o_eop),
      .i_rd_rdy(i_rd_rdy), .o_crc_err(o_crc_err),
      .o_blk_free_vld(o_blk_free_vld), .o_blk_free_addr(o_blk_free_addr)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // ---------------- environment models ----------------
   logic [31:0] mem [0:2047];
   logic [7:0]  lnk [0:255];
   int          lk_delay = 1;
   int          lk_cnt;
   logic [7:0]  lk_addr;
   int          rdy_mode = 0;
   int          cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      i_sram_rd_data <= o_sram_rd_en ? mem[o_sram_rd_addr] : 32'hDEAD_BEEF;
   end

   always @(posedge clk) begin
      if (i_rst) begin
         lk_cnt <= 0;
         i_link_vld <= 1'b0;
         i_link_addr <= 8'h0;
      end else begin
         i_link_vld <= 1'b0;
         if (o_link_req) begin
            lk_cnt  <= lk_delay;
            lk_addr <= lnk[o_link_cur];
         end else if (lk_cnt == 1) begin
            i_link_vld  <= 1'b1;
            i_link_addr <= lk_addr;
            lk_cnt      <= 0;
         end else if (lk_cnt > 1) begin
            lk_cnt <= lk_cnt - 1;
         end
      end
   end

   initial begin
      int k = 0;
      i_rd_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1:       i_rd_rdy = (k % 4 == 0) || (k % 4 == 3);
            2:       i_rd_rdy = 1'($urandom_range(0, 1));
            default: i_rd_rdy = 1'b1;
         endcase
         k++;
      end
   end

   // ---------------- monitors ----------------
   typedef struct packed { logic sop; logic eop; logic [31:0] d; } beat_t;
   beat_t       got_beats[$], exp_beats[$];
   int          got_cyc[$];
   logic [10:0] got_reads[$], exp_reads[$];
   logic [7:0]  got_frees[$], exp_frees[$], got_links[$], exp_links[$];
   int          got_err = 0;
   int          exp_err = 0;
   logic        prev_stall = 1'b0;
   beat_t       prev_beat;

   always @(negedge clk) begin
      if (i_rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall)
            chk("hold_while_stalled", {o_rd_vld, o_sop, o_eop, o_rd_data},
                {1'b1, prev_beat.sop, prev_beat.eop, prev_beat.d});
         prev_stall <= o_rd_vld && !i_rd_rdy;
         prev_beat  <= '{o_sop, o_eop, o_rd_data};
         if (o_rd_vld && i_rd_rdy) begin
            got_beats.push_back('{o_sop, o_eop, o_rd_data});
            got_cyc.push_back(cyc);
         end
         if (o_sram_rd_en)   got_reads.push_back(o_sram_rd_addr);
         if (o_blk_free_vld) got_frees.push_back(o_blk_free_addr);
         if (o_link_req)     got_links.push_back(o_link_cur);
         if (o_crc_err)      got_err++;
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [31:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 31; i >= 0; i--)
         r = (r[31] ^ d[i]) ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
      return r;
   endfunction

   // Packet word k lives in chain block k/8 at offset k%8; word len is CRC.
   task automatic prep(input logic [7:0] first, input int len, input int step, input bit corrupt);
      logic [7:0]  ch [0:7];
      logic [31:0] crc, w;
      logic [10:0] a;
      int          nblk;
      nblk = (len + 8) / 8;
      ch[0] = first;
      for (int i = 1; i < nblk; i++) ch[i] = ch[i-1] + 8'(step);
      exp_beats.delete(); exp_reads.delete(); exp_frees.delete(); exp_links.delete();
      crc = 32'hFFFF_FFFF;
      for (int k = 0; k <= len; k++) begin
         a = {ch[k/8], 3'(k % 8)};
         exp_reads.push_back(a);
         if (k < len) begin
            w = $urandom;
            mem[a] = w;
            crc = crc_ref(crc, w);
            exp_beats.push_back('{k == 0, k == len - 1, w});
         end else begin
            mem[a] = corrupt ? (crc ^ 32'h1) : crc;
         end
      end
      for (int i = 0; i < nblk; i++) begin
         exp_frees.push_back(ch[i]);
         if (i < nblk - 1) begin
            lnk[ch[i]] = ch[i+1];
            exp_links.push_back(ch[i]);
         end
      end
`ifdef OUTPUT_CHANNEL_CRC_CHECK_EN
      exp_err = corrupt ? 1 : 0;
`else
      exp_err = 0;
`endif
   endtask

   task automatic send(input logic [7:0] blk, input int len);
      for (int c = 0; c < 50 && !o_desc_rdy; c++) @(negedge clk);
      chk("desc_rdy", o_desc_rdy, 1'b1);
      got_beats.delete(); got_cyc.delete(); got_reads.delete();
      got_frees.delete(); got_links.delete(); got_err = 0;
      i_desc_vld = 1'b1; i_desc_blk_addr = blk; i_desc_len = 12'(len);
      @(posedge clk); #1;
      i_desc_vld = 1'b0;
   endtask

   task automatic finish_and_check();
      int c;
      for (c = 0; c < 3000 && got_frees.size() < exp_frees.size(); c++) @(negedge clk);
      chk("pkt_completes", c < 3000, 1'b1);
      repeat (4) @(negedge clk);
      chk("n_beats", got_beats.size(), exp_beats.size());
      for (int i = 0; i < got_beats.size() && i < exp_beats.size(); i++)
         chk("beat", got_beats[i], exp_beats[i]);
      chk("n_reads", got_reads.size(), exp_reads.size());
      for (int i = 0; i < got_reads.size() && i < exp_reads.size(); i++)
         chk("rd_addr", got_reads[i], exp_reads[i]);
      chk("n_frees", got_frees.size(), exp_frees.size());
      for (int i = 0; i < got_frees.size() && i < exp_frees.size(); i++)
         chk("free_addr", got_frees[i], exp_frees[i]);
      chk("n_links", got_links.size(), exp_links.size());
      for (int i = 0; i < got_links.size() && i < exp_links.size(); i++)
         chk("link_cur", got_links[i], exp_links[i]);
      chk("crc_err", got_err, exp_err);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [7:0]  blk;
      int          len, step, mode;
      bit          corrupt;
      logic [10:0] first_rd, last_rd;
      int          nfree;
      logic [7:0]  last_free;
      int          nbeats;
      int          span;   // cycles from first to last beat, -1 = unchecked
   } vec_t;

   vec_t vt[8];

   initial begin
      vt[0] = '{8'h10,  5, 1, 0, 0, 11'h080, 11'h085, 1, 8'h10,  5,  4};
      vt[1] = '{8'h03,  8, 4, 0, 0, 11'h018, 11'h038, 2, 8'h07,  8, -1};
      vt[2] = '{8'h20, 12, 1, 1, 0, 11'h100, 11'h10C, 2, 8'h21, 12, -1};
      vt[3] = '{8'h30,  3, 1, 0, 1, 11'h180, 11'h183, 1, 8'h30,  3, -1};
      vt[4] = '{8'h40,  1, 1, 0, 0, 11'h200, 11'h201, 1, 8'h40,  1, -1};
      vt[5] = '{8'h50,  0, 1, 0, 0, 11'h280, 11'h280, 1, 8'h50,  0, -1};
      vt[6] = '{8'h60,  7, 1, 0, 0, 11'h300, 11'h307, 1, 8'h60,  7,  6};
      vt[7] = '{8'h70, 16, 1, 2, 0, 11'h380, 11'h390, 3, 8'h72, 16, -1};

      i_rst = 1'b1; i_desc_vld = 1'b0; i_desc_blk_addr = '0; i_desc_len = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ctrl", {o_desc_rdy, o_link_req, o_sram_rd_en, o_sop, o_rd_vld,
                       o_eop, o_crc_err, o_blk_free_vld}, 8'h0);
      chk("rst_data", o_rd_data, 32'h0);
      i_rst = 1'b0;

      foreach (vt[v]) begin
         rdy_mode = vt[v].mode;
         lk_delay = 2;
         prep(vt[v].blk, vt[v].len, vt[v].step, vt[v].corrupt);
         send(vt[v].blk, vt[v].len);
         finish_and_check();
         chk("vec_first_rd", got_reads.size() > 0 ? got_reads[0] : 11'h7FF, vt[v].first_rd);
         chk("vec_last_rd", got_reads.size() > 0 ? got_reads[$] : 11'h7FF, vt[v].last_rd);
         chk("vec_nfree", got_frees.size(), vt[v].nfree);
         chk("vec_last_free", got_frees.size() > 0 ? got_frees[$] : 8'hEE, vt[v].last_free);
         chk("vec_nbeats", got_beats.size(), vt[v].nbeats);
         if (vt[v].span >= 0)
            chk("vec_span", got_cyc.size() > 0 ? got_cyc[$] - got_cyc[0] : -1, vt[v].span);
      end

      // ---------------- randomized packets ----------------
      for (int n = 0; n < 25; n++) begin
         int          len;
         logic [7:0]  blk;
         bit          bad;
         len      = $urandom_range(0, 40);
         blk      = 8'($urandom_range(0, 255));
         bad      = ($urandom_range(0, 3) == 0);
         rdy_mode = $urandom_range(0, 2);
         lk_delay = $urandom_range(1, 4);
         prep(blk, len, 37, bad);
         send(blk, len);
         finish_and_check();
      end

      // ---------------- reset mid-packet ----------------
      begin
         int c;
         rdy_mode = 0;
         lk_delay = 2;
         prep(8'h90, 20, 1, 0);
         send(8'h90, 20);
         for (c = 0; c < 100 && got_reads.size() < 4; c++) @(negedge clk);
         chk("mid_reads_seen", c < 100, 1'b1);
         @(posedge clk); #1;
         i_rst = 1'b1;
         @(posedge clk);
         @(negedge clk);
         chk("midrst_ctrl", {o_desc_rdy, o_link_req, o_sram_rd_en, o_sop, o_rd_vld,
                             o_eop, o_crc_err, o_blk_free_vld}, 8'h0);
         chk("midrst_data", {o_rd_data, o_sram_rd_addr, o_link_cur, o_blk_free_addr}, '0);
         i_rst = 1'b0;
         for (c = 0; c < 10 && !o_desc_rdy; c++) @(negedge clk);
         chk("midrst_rdy_after", o_desc_rdy, 1'b1);
         repeat (20) @(negedge clk);
         chk("midrst_no_free", got_frees.size(), 0);
         chk("midrst_no_link", got_links.size(), 0);
         // channel must be usable again
         prep(8'hA0, 9, 1, 0);
         send(8'hA0, 9);
         finish_and_check();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
